// File: rtl/addsub_rr_arbiter.sv
// addsub_rr_arbiter: round-robin sharing of one combinational FP32 add/sub unit
//   add_sub            : i_a, i_b, i_checkequation (0 add, 1 sub) -> o_result, o_overflow, o_underflow
//   addsub_rr_arbiter  : req_valid/req_ready/req_a/req_b/req_op per requester,
//                        rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_overflow/rsp_underflow,
//                        ovf_count/unf_count saturating event counters, clr_count
// Arithmetic: round-to-nearest-even, subnormal inputs read as zero, tiny results flushed
// to signed zero with underflow, huge results become signed infinity with overflow,
// NaN in or inf-inf gives 0x7FC00000, other infinities pass through.
module add_sub (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_checkequation,
  output logic [31:0] o_result,
  output logic        o_overflow,
  output logic        o_underflow
);
  logic              w_sb, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_swap, w_sl, w_ss, w_st, w_rnd;
  logic [7:0]        w_el, w_es, w_d;
  logic [23:0]       w_ml, w_ms;
  logic [49:0]       w_t;
  logic [26:0]       w_al, w_n;
  logic [27:0]       w_sum;
  logic [4:0]        w_lz;
  logic [24:0]       w_mr;
  logic signed [9:0] w_e;
  assign w_sb    = i_b[31] ^ i_checkequation;
  assign w_a_nan = (&i_a[30:23]) & (|i_a[22:0]);
  assign w_b_nan = (&i_b[30:23]) & (|i_b[22:0]);
  assign w_a_inf = (&i_a[30:23]) & ~(|i_a[22:0]);
  assign w_b_inf = (&i_b[30:23]) & ~(|i_b[22:0]);
  // order operands by magnitude so the difference is never negative
  assign w_swap = ((i_b[30:23] == 8'd0) ? 31'd0 : i_b[30:0]) > ((i_a[30:23] == 8'd0) ? 31'd0 : i_a[30:0]);
  assign w_el   = w_swap ? i_b[30:23] : i_a[30:23];
  assign w_es   = w_swap ? i_a[30:23] : i_b[30:23];
  assign w_sl   = w_swap ? w_sb : i_a[31];
  assign w_ss   = w_swap ? i_a[31] : w_sb;
  assign w_ml   = (w_el == 8'd0) ? 24'd0 : {1'b1, w_swap ? i_b[22:0] : i_a[22:0]};
  assign w_ms   = (w_es == 8'd0) ? 24'd0 : {1'b1, w_swap ? i_a[22:0] : i_b[22:0]};
  assign w_d    = w_el - w_es;
  // align smaller operand keeping guard, round and a sticky OR of everything shifted out
  assign w_t    = {w_ms, 26'd0} >> w_d;
  assign w_st   = (w_d > 8'd26) ? |w_ms : |w_t[23:0];
  assign w_al   = {w_t[49:24], w_st};
  assign w_sum  = (w_sl ^ w_ss) ? {1'b0, w_ml, 3'b000} - {1'b0, w_al} : {1'b0, w_ml, 3'b000} + {1'b0, w_al};
  always_comb begin
    w_lz = 5'd0;
    for (int i = 0; i < 27; i++) if (w_sum[i]) w_lz = 5'(26 - i);
  end
  assign w_n   = w_sum[27] ? {w_sum[27:2], w_sum[1] | w_sum[0]} : w_sum[26:0] << w_lz;
  assign w_rnd = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
  assign w_mr  = {1'b0, w_n[26:3]} + 25'(w_rnd);
  assign w_e   = 10'(w_el) + (w_sum[27] ? 10'd1 : -10'(w_lz)) + 10'(w_mr[24]);
  always_comb begin
    o_overflow  = 1'b0;
    o_underflow = 1'b0;
    if (w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (i_a[31] ^ w_sb))) o_result = 32'h7FC00000;
    else if (w_a_inf) o_result = {i_a[31], 31'h7F800000};
    else if (w_b_inf) o_result = {w_sb, 31'h7F800000};
    else if (w_sum == 28'd0) o_result = {w_sl & w_ss, 31'd0};
    else if (w_e >= 10'sd255) begin
      o_result   = {w_sl, 31'h7F800000};
      o_overflow = 1'b1;
    end else if (w_e < 10'sd1) begin
      o_result    = {w_sl, 31'd0};
      o_underflow = 1'b1;
    end else o_result = {w_sl, w_e[7:0], w_mr[24] ? w_mr[23:1] : w_mr[22:0]};
  end
endmodule

module addsub_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ-1:0]    req_op,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [31:0]        rsp_result,
  output logic               rsp_overflow,
  output logic               rsp_underflow,
  output logic [CNT_W-1:0]   ovf_count,
  output logic [CNT_W-1:0]   unf_count,
  input  logic               clr_count
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;
  logic [0:0]       r_state;
  logic [ID_W-1:0]  r_last, r_id;
  logic [31:0]      r_result;
  logic             r_ovf, r_unf;
  logic [CNT_W-1:0] r_ovf_cnt, r_unf_cnt;
  logic [ID_W-1:0]  w_gnt;
  logic             w_any, w_acc, w_ovf, w_unf;
  logic [31:0]      w_res;
  // scan from farthest to nearest so the nearest requester after r_last wins
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[(int'(r_last) + k) % NREQ]) begin
        w_any = 1'b1;
        w_gnt = ID_W'((int'(r_last) + k) % NREQ);
      end
    end
  end
  assign w_acc     = w_any & ((r_state == EMPTY) | rsp_ready) & ~rst;
  assign req_ready = w_acc ? {{(NREQ-1){1'b0}}, 1'b1} << w_gnt : '0;
  add_sub u_add_sub (
    .i_a             (req_a[32*w_gnt +: 32]),
    .i_b             (req_b[32*w_gnt +: 32]),
    .i_checkequation (req_op[w_gnt]),
    .o_result        (w_res),
    .o_overflow      (w_ovf),
    .o_underflow     (w_unf)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= EMPTY;
      r_last    <= ID_W'(NREQ - 1);
      r_id      <= '0;
      r_result  <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      r_ovf_cnt <= '0;
      r_unf_cnt <= '0;
    end else begin
      if (w_acc) begin
        r_state  <= FULL;
        r_last   <= w_gnt;
        r_id     <= w_gnt;
        r_result <= w_res;
        r_ovf    <= w_ovf;
        r_unf    <= w_unf;
      end else if (rsp_ready) r_state <= EMPTY;
      r_ovf_cnt <= clr_count ? '0 : (w_acc & w_ovf & ~&r_ovf_cnt) ? r_ovf_cnt + 1'b1 : r_ovf_cnt;
      r_unf_cnt <= clr_count ? '0 : (w_acc & w_unf & ~&r_unf_cnt) ? r_unf_cnt + 1'b1 : r_unf_cnt;
    end
  end
  assign rsp_valid     = r_state == FULL;
  assign rsp_id        = r_id;
  assign rsp_result    = r_result;
  assign rsp_overflow  = r_ovf;
  assign rsp_underflow = r_unf;
  assign ovf_count     = r_ovf_cnt;
  assign unf_count     = r_unf_cnt;
endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// tb_addsub_rr_arbiter: scoreboard bench with an exact-arithmetic FP32 reference model
module tb_addsub_rr_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid, req_ready, req_op;
  logic [127:0] req_a, req_b;
  logic         rsp_valid, rsp_ready, rsp_overflow, rsp_underflow, clr_count;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_result;
  logic [3:0]   ovf_count, unf_count;
  int           vectors, miscompares;
  int           m_last, m_ovf, m_unf;
  bit           m_valid;
  logic [35:0]  sb[$];

  addsub_rr_arbiter #(.NREQ(4), .ID_W(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow), .rsp_underflow(rsp_underflow),
    .ovf_count(ovf_count), .unf_count(unf_count), .clr_count(clr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // exact sum as a wide integer scaled by 2^149, then one rounding to 24 bits
  function automatic logic [33:0] fp_ref(input logic [31:0] a, input logic [31:0] b, input logic op);
    logic sb_, an, bn, ai, bi, neg;
    logic [299:0] ma, mb, mag, q, rem, half;
    logic signed [299:0] s;
    int p, e, sh;
    sb_ = b[31] ^ op;
    an = a[30:23] == 8'hFF && a[22:0] != 0;
    bn = b[30:23] == 8'hFF && b[22:0] != 0;
    ai = a[30:23] == 8'hFF && a[22:0] == 0;
    bi = b[30:23] == 8'hFF && b[22:0] == 0;
    if (an || bn || (ai && bi && a[31] != sb_)) return {2'b00, 32'h7FC00000};
    if (ai) return {2'b00, a[31], 31'h7F800000};
    if (bi) return {2'b00, sb_, 31'h7F800000};
    ma = (a[30:23] == 0) ? '0 : 300'({1'b1, a[22:0]}) << (a[30:23] - 8'd1);
    mb = (b[30:23] == 0) ? '0 : 300'({1'b1, b[22:0]}) << (b[30:23] - 8'd1);
    s = $signed(a[31] ? -ma : ma) + $signed(sb_ ? -mb : mb);
    if (s == 0) return {2'b00, a[31] & sb_, 31'd0};
    neg = s < 0;
    mag = neg ? 300'(-s) : 300'(s);
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    e = p - 22;
    if (p > 23) begin
      sh = p - 23;
      q = mag >> sh;
      rem = mag - (q << sh);
      half = 300'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
    end else q = mag << (23 - p);
    if (q[24]) begin
      q = q >> 1;
      e++;
    end
    if (e >= 255) return {2'b10, neg, 31'h7F800000};
    if (e <= 0) return {2'b01, neg, 31'd0};
    return {2'b00, neg, 8'(e), q[22:0]};
  endfunction

  function automatic int pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++) if (v[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  function automatic logic [31:0] rfp();
    logic s;
    logic [22:0] f;
    s = 1'($urandom);
    f = 23'($urandom);
    case ($urandom_range(0, 7))
      0: return $urandom();
      1: return {s, 8'(252 + $urandom_range(0, 2)), f};
      2: return {s, 8'($urandom_range(1, 3)), f};
      3: return {s, 8'hFF, $urandom_range(0, 1) ? 23'd0 : f};
      4: return {s, 8'd0, f};
      default: return {s, 8'($urandom_range(120, 134)), f};
    endcase
  endfunction

  // reference model: advances on the same edge as the DUT, pushes expected responses
  always @(posedge clk or posedge rst) begin : model
    int w;
    bit acc;
    logic [33:0] r;
    if (rst) begin
      m_last = 3; m_valid = 0; m_ovf = 0; m_unf = 0;
      sb.delete();
    end else begin
      w = pick(req_valid, m_last);
      acc = w >= 0 && (!m_valid || rsp_ready);
      r = '0;
      if (acc) begin
        r = fp_ref(req_a[32*w +: 32], req_b[32*w +: 32], req_op[w]);
        sb.push_back({2'(w), r});
        m_last = w;
        m_valid = 1;
      end else if (rsp_ready) m_valid = 0;
      if (clr_count) begin
        m_ovf = 0; m_unf = 0;
      end else if (acc) begin
        if (r[33] && m_ovf < 15) m_ovf++;
        if (r[32] && m_unf < 15) m_unf++;
      end
    end
  end

  // monitor: checks handshake, counters and the presented response every cycle
  always @(negedge clk) begin : monitor
    int w;
    logic [3:0] e_rdy;
    if (!rst) begin
      w = pick(req_valid, m_last);
      e_rdy = (w >= 0 && (!m_valid || rsp_ready)) ? 4'b1 << w : 4'b0;
      chk("req_ready", 64'(req_ready), 64'(e_rdy));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
      chk("ovf_count", 64'(ovf_count), 64'(m_ovf));
      chk("unf_count", 64'(unf_count), 64'(m_unf));
      if (rsp_valid) begin
        if (sb.size() == 0) chk("rsp_unexpected", 64'(1), 64'(0));
        else begin
          chk("rsp", 64'({rsp_id, rsp_overflow, rsp_underflow, rsp_result}), 64'(sb[0]));
          if (rsp_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic all_ops(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
    end
    req_op = 4'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1; req_valid = 0; req_a = '0; req_b = '0; req_op = 0; rsp_ready = 0; clr_count = 0;
    repeat (2) @(posedge clk);
    #2;
    req_valid = 4'hF;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_id", 64'(rsp_id), 64'(0));
    chk("rst_rsp_result", 64'(rsp_result), 64'(0));
    chk("rst_flags", 64'({rsp_overflow, rsp_underflow}), 64'(0));
    chk("rst_counts", 64'({ovf_count, unf_count}), 64'(0));
    req_valid = 0;
    cyc();
    rst = 0;
    req_valid = 4'b0001; req_a[31:0] = 32'h3F800000; req_b[31:0] = 32'h40000000;
    cyc();
    chk("add_valid", 64'(rsp_valid), 64'(1));
    chk("add_result", 64'(rsp_result), 64'h40400000);
    chk("add_id", 64'(rsp_id), 64'(0));
    chk("add_ovf", 64'(rsp_overflow), 64'(0));
    req_valid = 0;
    cyc();
    req_valid = 4'b0100; req_a[95:64] = 32'h40400000; req_b[95:64] = 32'h3F800000; req_op[2] = 1'b1;
    rsp_ready = 1;
    cyc();
    chk("sub_result", 64'(rsp_result), 64'h40000000);
    chk("sub_id", 64'(rsp_id), 64'(2));
    req_valid = 0;
    cyc();
    chk("drain_valid", 64'(rsp_valid), 64'(0));
    rst = 1;
    cyc();
    cyc();
    rst = 0;
    all_ops(32'h3F800000, 32'h40000000);
    req_valid = 4'hF;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("rr_id", 64'(rsp_id), 64'(i % 4));
    end
    rsp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_id", 64'(rsp_id), 64'(1));
      chk("stall_ready", 64'(req_ready), 64'(0));
    end
    rsp_ready = 1;
    cyc();
    chk("resume_id", 64'(rsp_id), 64'(2));
    req_valid = 4'b0001; req_a[31:0] = 32'h7F7FFFFF; req_b[31:0] = 32'h7F7FFFFF;
    cyc();
    chk("ovf_result", 64'(rsp_result), 64'h7F800000);
    chk("ovf_flag", 64'(rsp_overflow), 64'(1));
    chk("ovf_count_1", 64'(ovf_count), 64'(1));
    clr_count = 1;
    cyc();
    chk("ovf_clr", 64'(ovf_count), 64'(0));
    clr_count = 0;
    rsp_ready = 0;
    cyc();
    rst = 1;
    #1;
    chk("async_rst_valid", 64'(rsp_valid), 64'(0));
    all_ops(32'h3F800000, 32'h40000000);
    req_valid = 4'hF;
    cyc();
    cyc();
    rst = 0;
    rsp_ready = 1;
    cyc();
    chk("post_rst_id", 64'(rsp_id), 64'(0));
    chk("post_rst_valid", 64'(rsp_valid), 64'(1));
    for (int n = 0; n < 3000; n++) begin
      req_valid = 4'($urandom);
      req_op = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        req_a[32*i +: 32] = rfp();
        req_b[32*i +: 32] = ($urandom_range(0, 4) == 0) ? req_a[32*i +: 32] ^ 32'($urandom_range(0, 7)) : rfp();
      end
      rsp_ready = $urandom_range(0, 3) != 0;
      clr_count = $urandom_range(0, 49) == 0;
      cyc();
    end
    req_valid = 0; rsp_ready = 1; clr_count = 0;
    repeat (3) cyc();
    chk("drained", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
